// File: rtl/inst_sequencer.sv
// Instruction queue and issue controller for the PUSH/ADD/MULT/SEND calculator.
// Buffers 8-bit instruction words and issues them as single-cycle strobes,
// holding SEND while the UART is busy and waiting for its completion pulse.
module inst_sequencer #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int TX_TIMEOUT = 2000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_vld,
  input  logic [7:0]    load_inst,
  input  logic          run,
  input  logic          step_mode,
  input  logic          clr,
  input  logic          tx_busy,
  input  logic          tx_done,
  output logic          inst_vld,
  output logic [7:0]    inst_wd,
  output logic [AW:0]   q_count,
  output logic          q_full,
  output logic          busy,
  output logic          ovf_err,
  output logic          tx_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_TX} state_t;

  localparam int              TW       = $clog2(TX_TIMEOUT + 1);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     ONE_CNT  = (AW+1)'(1);
  localparam logic [TW-1:0]   TMR_LAST = TW'(TX_TIMEOUT - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state, state_nxt;
  logic [TW-1:0] tmr;

  logic       full, wr_en, drop;
  logic       pop, tmr_clr, tmr_inc, tx_err_set;
  logic [7:0] head;
  logic       head_send;

  // Fullness is judged before any same-cycle pop, so a load into a full
  // queue is dropped even if a word leaves in that cycle.
  assign full      = (count == FULL_CNT);
  assign wr_en     = load_vld && !full && !clr;
  assign drop      = load_vld && full && !clr;
  assign head      = mem[rd_ptr];
  assign head_send = (head[7:6] == 2'b11);

  assign q_count = count;
  assign q_full  = full;
  assign busy    = (state != IDLE);

  // Next-state and issue decisions.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    tx_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (run && (count != '0)) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (count == '0) begin
          state_nxt = IDLE;
        end else if (!(head_send && tx_busy)) begin
          pop = 1'b1;
          if (head_send) begin
            state_nxt = WAIT_TX;
            tmr_clr   = 1'b1;
          end else if (step_mode || (count == ONE_CNT)) begin
            // A word loaded in this same cycle does not keep the burst going.
            state_nxt = IDLE;
          end
        end
      end
      WAIT_TX: begin
        if (tx_done) begin
          state_nxt = (step_mode || (count == '0)) ? IDLE : ISSUE;
        end else if (tmr == TMR_LAST) begin
          tx_err_set = 1'b1;
          state_nxt  = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; clr forces the reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= state_nxt;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= load_inst;
  end

  // SEND completion timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tmr <= '0;
    else if (clr)     tmr <= '0;
    else if (tmr_clr) tmr <= '0;
    else if (tmr_inc) tmr <= tmr + TW'(1);
  end

  // Registered issue strobe and word; the word holds between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_vld <= 1'b0;
      inst_wd  <= 8'h00;
    end else if (clr) begin
      inst_vld <= 1'b0;
      inst_wd  <= 8'h00;
    end else begin
      inst_vld <= pop;
      if (pop) inst_wd <= head;
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      tx_err  <= 1'b0;
    end else if (clr) begin
      ovf_err <= 1'b0;
      tx_err  <= 1'b0;
    end else begin
      if (drop)       ovf_err <= 1'b1;
      if (tx_err_set) tx_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed self-checking bench for inst_sequencer (DEPTH=8, TX_TIMEOUT=50).
module tb_inst_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_vld;
  logic [7:0] load_inst;
  logic       run;
  logic       step_mode;
  logic       clr;
  logic       tx_busy;
  logic       tx_done;
  logic       inst_vld;
  logic [7:0] inst_wd;
  logic [3:0] q_count;
  logic       q_full;
  logic       busy;
  logic       ovf_err;
  logic       tx_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  inst_sequencer #(.DEPTH(8), .AW(3), .TX_TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .load_vld(load_vld), .load_inst(load_inst),
    .run(run), .step_mode(step_mode), .clr(clr), .tx_busy(tx_busy),
    .tx_done(tx_done), .inst_vld(inst_vld), .inst_wd(inst_wd),
    .q_count(q_count), .q_full(q_full), .busy(busy), .ovf_err(ovf_err),
    .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] w);
    load_vld  = 1'b1;
    load_inst = w;
    tick();
    load_vld  = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    rst_n = 1'b0; load_vld = 1'b0; load_inst = 8'h00; run = 1'b0;
    step_mode = 1'b0; clr = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
    tick(); tick();
    outs = {inst_vld, inst_wd, q_count, q_full, busy};
    total_cnt++;
    if (outs !== 15'd0) $display("FAIL reset_outputs got %h want 0", outs);
    else pass_cnt++;
    total_cnt++;
    if ({ovf_err, tx_err} !== 2'b00) $display("FAIL reset_flags got %b want 00", {ovf_err, tx_err});
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    // run on an empty queue must be ignored
    pulse_run();
    tick();
    total_cnt++;
    if ({busy, inst_vld} !== 2'b00) $display("FAIL run_empty got %b want 00", {busy, inst_vld});
    else pass_cnt++;
  endtask

  task automatic test_burst();
    logic [7:0] exp_wd [5];
    exp_wd[0] = 8'h04; exp_wd[1] = 8'h00; exp_wd[2] = 8'h13;
    exp_wd[3] = 8'h86; exp_wd[4] = 8'h63;
    step_mode = 1'b0;
    for (int i = 0; i < 5; i++) do_load(exp_wd[i]);
    total_cnt++;
    if (q_count !== 4'd5) $display("FAIL burst_count got %0d want 5", q_count);
    else pass_cnt++;
    pulse_run();
    total_cnt++;
    if ({busy, inst_vld} !== 2'b10) $display("FAIL burst_latency got %b want 10", {busy, inst_vld});
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (inst_vld !== 1'b1 || inst_wd !== exp_wd[i] || q_count !== 4'(4 - i))
        $display("FAIL burst_issue%0d got vld=%b wd=%h cnt=%0d want vld=1 wd=%h cnt=%0d",
                 i, inst_vld, inst_wd, q_count, exp_wd[i], 4 - i);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (inst_vld !== 1'b0 || busy !== 1'b0 || inst_wd !== 8'h63)
      $display("FAIL burst_end got vld=%b busy=%b wd=%h want vld=0 busy=0 wd=63", inst_vld, busy, inst_wd);
    else pass_cnt++;
  endtask

  task automatic test_send_stall();
    int vld_seen;
    // tx_done while idle is ignored
    tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL done_idle got busy=%b want 0", busy);
    else pass_cnt++;
    do_load(8'hC0);
    do_load(8'h04);
    tx_busy = 1'b1;
    pulse_run();
    vld_seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (inst_vld === 1'b1) vld_seen++;
    end
    total_cnt++;
    if (vld_seen != 0 || busy !== 1'b1 || q_count !== 4'd2)
      $display("FAIL send_stall got issues=%0d busy=%b cnt=%0d want 0 1 2", vld_seen, busy, q_count);
    else pass_cnt++;
    tx_busy = 1'b0;
    tick();
    total_cnt++;
    if (inst_vld !== 1'b1 || inst_wd !== 8'hC0 || q_count !== 4'd1)
      $display("FAIL send_issue got vld=%b wd=%h cnt=%0d want 1 c0 1", inst_vld, inst_wd, q_count);
    else pass_cnt++;
    vld_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (inst_vld === 1'b1) vld_seen++;
    end
    total_cnt++;
    if (vld_seen != 0 || busy !== 1'b1)
      $display("FAIL send_wait got issues=%0d busy=%b want 0 1", vld_seen, busy);
    else pass_cnt++;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total_cnt++;
    if (inst_vld !== 1'b0) $display("FAIL after_done_early got vld=%b want 0", inst_vld);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (inst_vld !== 1'b1 || inst_wd !== 8'h04)
      $display("FAIL after_done_issue got vld=%b wd=%h want 1 04", inst_vld, inst_wd);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, inst_vld, tx_err} !== 3'b000)
      $display("FAIL send_end got %b want 000", {busy, inst_vld, tx_err});
    else pass_cnt++;
  endtask

  task automatic test_step();
    int vld_seen;
    step_mode = 1'b1;
    do_load(8'h04);
    do_load(8'h13);
    pulse_run();
    tick();
    total_cnt++;
    if (inst_vld !== 1'b1 || inst_wd !== 8'h04)
      $display("FAIL step1 got vld=%b wd=%h want 1 04", inst_vld, inst_wd);
    else pass_cnt++;
    vld_seen = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (inst_vld === 1'b1) vld_seen++;
    end
    total_cnt++;
    if (vld_seen != 0 || busy !== 1'b0 || q_count !== 4'd1)
      $display("FAIL step_gap got issues=%0d busy=%b cnt=%0d want 0 0 1", vld_seen, busy, q_count);
    else pass_cnt++;
    pulse_run();
    tick();
    total_cnt++;
    if (inst_vld !== 1'b1 || inst_wd !== 8'h13)
      $display("FAIL step2 got vld=%b wd=%h want 1 13", inst_vld, inst_wd);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, inst_vld} !== 2'b00 || q_count !== 4'd0)
      $display("FAIL step_end got busy/vld=%b cnt=%0d want 00 0", {busy, inst_vld}, q_count);
    else pass_cnt++;
    step_mode = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) do_load(8'(i + 1));
    total_cnt++;
    if (q_full !== 1'b1 || q_count !== 4'd8 || ovf_err !== 1'b0)
      $display("FAIL fill got full=%b cnt=%0d ovf=%b want 1 8 0", q_full, q_count, ovf_err);
    else pass_cnt++;
    do_load(8'hFF);
    total_cnt++;
    if (ovf_err !== 1'b1 || q_count !== 4'd8)
      $display("FAIL overflow got ovf=%b cnt=%0d want 1 8", ovf_err, q_count);
    else pass_cnt++;
    pulse_run();
    // load into the full queue in the same cycle as the first pop
    load_vld = 1'b1;
    load_inst = 8'hFF;
    tick();
    load_vld = 1'b0;
    total_cnt++;
    if (inst_vld !== 1'b1 || inst_wd !== 8'h01 || q_count !== 4'd7 || q_full !== 1'b0)
      $display("FAIL full_pop got vld=%b wd=%h cnt=%0d full=%b want 1 01 7 0",
               inst_vld, inst_wd, q_count, q_full);
    else pass_cnt++;
    for (int i = 2; i <= 8; i++) begin
      tick();
      total_cnt++;
      if (inst_vld !== 1'b1 || inst_wd !== 8'(i))
        $display("FAIL drain%0d got vld=%b wd=%h want 1 %h", i, inst_vld, inst_wd, 8'(i));
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({busy, inst_vld} !== 2'b00 || q_count !== 4'd0 || ovf_err !== 1'b1)
      $display("FAIL drain_end got busy/vld=%b cnt=%0d ovf=%b want 00 0 1",
               {busy, inst_vld}, q_count, ovf_err);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int early_err;
    do_load(8'hC3);
    pulse_run();
    tick();
    total_cnt++;
    if (inst_vld !== 1'b1 || inst_wd !== 8'hC3)
      $display("FAIL to_issue got vld=%b wd=%h want 1 c3", inst_vld, inst_wd);
    else pass_cnt++;
    early_err = 0;
    for (int i = 0; i < 49; i++) begin
      tick();
      if (tx_err !== 1'b0) early_err++;
    end
    total_cnt++;
    if (early_err != 0 || busy !== 1'b1)
      $display("FAIL to_early got early=%0d busy=%b want 0 1", early_err, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (tx_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL to_fire got tx_err=%b busy=%b want 1 0", tx_err, busy);
    else pass_cnt++;
    do_load(8'h11);
    total_cnt++;
    if (q_count !== 4'd1) $display("FAIL pre_clr got cnt=%0d want 1", q_count);
    else pass_cnt++;
    clr = 1'b1;
    load_vld = 1'b1;
    load_inst = 8'h22;
    tick();
    clr = 1'b0;
    load_vld = 1'b0;
    total_cnt++;
    if ({tx_err, ovf_err, busy, inst_vld} !== 4'b0000 || q_count !== 4'd0 || inst_wd !== 8'h00)
      $display("FAIL clr got flags=%b cnt=%0d wd=%h want 0000 0 00",
               {tx_err, ovf_err, busy, inst_vld}, q_count, inst_wd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [14:0] outs;
    for (int i = 0; i < 5; i++) do_load(8'(8'h30 + i));
    pulse_run();
    tick();
    tick();
    total_cnt++;
    if (inst_vld !== 1'b1 || inst_wd !== 8'h31 || q_count !== 4'd3)
      $display("FAIL mid_pre got vld=%b wd=%h cnt=%0d want 1 31 3", inst_vld, inst_wd, q_count);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    outs = {inst_vld, inst_wd, q_count, q_full, busy};
    total_cnt++;
    if (outs !== 15'd0 || {ovf_err, tx_err} !== 2'b00)
      $display("FAIL async_reset got %h flags=%b want 0 00", outs, {ovf_err, tx_err});
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_run();
    tick();
    tick();
    total_cnt++;
    if ({busy, inst_vld} !== 2'b00 || q_count !== 4'd0)
      $display("FAIL post_reset_run got busy/vld=%b cnt=%0d want 00 0", {busy, inst_vld}, q_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_send_stall();
    test_step();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
Instruction queue and issue controller in front of the 4-register calculator datapath (PUSH/ADD/MULT/SEND) on the nexys3 top. It buffers 8-bit instruction words loaded from the switch/button path. On a run command it issues them to the datapath as single-cycle `inst_vld`/`inst_wd` strobes. SEND instructions are stalled while the UART transmitter is busy, and the sequencer waits for transmit completion before issuing the next instruction.

Parameters:
DEPTH, 8, queue depth in instruction words; power of two, 2..64
AW, 3, log2(DEPTH)
TX_TIMEOUT, 2000000, cycles to wait for `tx_done` after a SEND issue before flagging an error

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
load_vld  in  1  one-cycle strobe (debounced btnS); push `load_inst` into the queue
load_inst  in  8  instruction word; [7:6] opcode: 00 PUSH, 01 ADD, 10 MULT, 11 SEND
run  in  1  one-cycle strobe; start issuing queued instructions
step_mode  in  1  level; 1 = issue exactly one instruction per `run`
clr  in  1  synchronous flush: empty queue, go to IDLE, clear sticky flags
tx_busy  in  1  UART transmitter busy (level)
tx_done  in  1  one-cycle pulse when the UART finishes a byte
inst_vld  out  1  registered; one-cycle issue strobe to the datapath
inst_wd  out  8  registered; instruction word, valid while `inst_vld`=1
q_count  out  AW+1  number of queued words
q_full  out  1  `q_count`==DEPTH
busy  out  1  state != IDLE
ovf_err  out  1  sticky; a load was dropped because the queue was full
tx_err  out  1  sticky; SEND completion timed out

Behaviour:
- Reset (async, rst_n=0): queue empty, rd/wr pointers 0, state IDLE. All outputs 0: `inst_vld`, `inst_wd`=8'h00, `q_count`, `q_full`, `busy`, `ovf_err`, `tx_err`.
- Queue: circular buffer. Pointers wrap modulo DEPTH.
  - Write when `load_vld` and not `q_full`.
  - `load_vld` with `q_full`=1 (evaluated before any same-cycle pop): word dropped, `ovf_err` set.
  - Simultaneous accepted write and pop: `q_count` unchanged, both pointers advance.
- States: IDLE, ISSUE, WAIT_TX.
  - IDLE: `run`=1 with `q_count`>0 -> ISSUE. `run` with an empty queue is ignored. `load_vld` is accepted in every state.
  - ISSUE, head opcode 11 (SEND) with `tx_busy`=1: stall in ISSUE, no issue.
  - ISSUE, otherwise: at that edge register `inst_vld`=1, `inst_wd`=head, and pop.
    - SEND -> WAIT_TX, timeout counter cleared.
    - Non-SEND: if `step_mode`=1, or the queue becomes empty after the pop (including a same-cycle load into an empty queue) -> IDLE; else stay in ISSUE. Back-to-back non-SEND issues occur one per cycle.
  - WAIT_TX: on `tx_done`=1 -> IDLE if `step_mode`=1 or the queue is empty, else ISSUE.
    - Counter reaching TX_TIMEOUT-1 without `tx_done`: set `tx_err` -> IDLE.
    - `tx_done` seen in any other state is ignored.
- `inst_vld` is high for exactly one cycle per issued word and deasserts the following cycle. `inst_wd` holds its last value between issues.
- Latency: `run` sampled at edge N -> state ISSUE after N -> `inst_vld` high in the cycle after edge N+1.
- `run` while busy: ignored.
- `clr`: overrides everything except reset; same end state as reset. A load in the same cycle as `clr` is dropped.
- Reset mid-operation: immediate return to reset values. No partial issue is held.

Test Plan:
- Load 0x04, 0x00, 0x13, 0x86, 0x63 (step_mode=0), then pulse `run` -> `inst_vld` for 5 consecutive cycles, starting 2 cycles after `run`, with `inst_wd` 04, 00, 13, 86, 63; `q_count` 5 -> 0; `busy` ends 0.
- Load 0xC0, 0x04; `tx_busy`=1 for 10 cycles, then 0; `run` -> no issue while busy. 0xC0 issues one cycle after `tx_busy` falls. 0x04 is not issued until a `tx_done` pulse, then issues 2 cycles after `tx_done`.
- step_mode=1, load 0x04, 0x13; pulse `run` twice, 20 cycles apart -> exactly one `inst_vld` per `run` (04, then 13); `busy` returns to 0 between runs.
- Load DEPTH+1 words (8 then a 9th, 0xFF) -> `q_full`=1, `ovf_err`=1; 0xFF never issued. Full queue plus simultaneous load and pop -> load dropped, `q_count` goes 8 -> 7.
- SEND issued, no `tx_done` (TX_TIMEOUT overridden to 50) -> `tx_err`=1 at 50 cycles, state IDLE. A following `clr` clears `tx_err`, `q_count`=0.
- Assert `rst_n`=0 mid-run with 3 words still queued -> all outputs 0 asynchronously; after release, `run` has no effect (queue empty).
